// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one registered data-bus access per load/store and stalls until ack.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_stage (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  ex_rd_index_r,
  input  logic [31:0] ex_alu_res_r,
  input  logic [31:0] ex_mem_data_r,
  input  logic        ex_mem_rd_r,
  input  logic        ex_mem_wr_r,
  input  logic        ex_mem_signed_r,
  input  logic [1:0]  ex_mem_size_r,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  output logic        dbus_rd_o,
  output logic        dbus_wr_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [4:0]  mem_rd_index_r,
  output logic [31:0] mem_rd_value_r,
  output logic        mem_stall_w,
  output logic        mem_err_r
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      r_state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_is_load;
  logic [4:0]  r_idx;

  logic        w_is_mem;
  logic        w_trap;
  logic        w_start;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_val;

  assign w_is_mem = ex_mem_rd_r | ex_mem_wr_r;
  assign w_a      = ex_alu_res_r[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((ex_mem_size_r == 2'd1) & w_a[0]) |
                        (ex_mem_size_r[1] & (w_a != 2'b00));
  assign w_trap       = w_is_mem & w_misaligned;
`else
  assign w_trap    = 1'b0;
  assign mem_err_r = 1'b0;
`endif

  assign w_start     = (r_state == StIdle) & w_is_mem & ~w_trap;
  assign mem_stall_w = ~reset_i & (w_start | ((r_state == StBusy) & ~dbus_ack_i));

  always_comb begin
    case (ex_mem_size_r)
      2'd0: begin
        w_be    = 4'b0001 << w_a;
        w_wdata = {4{ex_mem_data_r[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << {w_a[1], 1'b0};
        w_wdata = {2{ex_mem_data_r[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_mem_data_r;
      end
    endcase
  end

  assign w_lane_byte = dbus_rdata_i[{r_lane, 3'b000} +: 8];
  assign w_lane_half = dbus_rdata_i[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'd0:    w_load_val = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
      2'd1:    w_load_val = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
      default: w_load_val = dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= StIdle;
      r_lane         <= 2'b00;
      r_size         <= 2'b00;
      r_signed       <= 1'b0;
      r_is_load      <= 1'b0;
      r_idx          <= 5'd0;
      dbus_addr_o    <= 32'd0;
      dbus_wdata_o   <= 32'd0;
      dbus_be_o      <= 4'd0;
      dbus_rd_o      <= 1'b0;
      dbus_wr_o      <= 1'b0;
      mem_rd_index_r <= 5'd0;
      mem_rd_value_r <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_err_r      <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      mem_err_r <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state        <= StBusy;
            r_lane         <= w_a;
            r_size         <= ex_mem_size_r;
            r_signed       <= ex_mem_signed_r;
            r_is_load      <= ex_mem_rd_r;
            r_idx          <= ex_rd_index_r;
            dbus_addr_o    <= {ex_alu_res_r[31:2], 2'b00};
            dbus_be_o      <= w_be;
            dbus_wdata_o   <= w_wdata;
            // A simultaneous rd+wr request is a load; no write is issued.
            dbus_rd_o      <= ex_mem_rd_r;
            dbus_wr_o      <= ~ex_mem_rd_r;
            mem_rd_index_r <= 5'd0;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (w_trap) begin
            mem_err_r      <= 1'b1;
            mem_rd_index_r <= 5'd0;
          end
`endif
          else begin
            mem_rd_index_r <= ex_rd_index_r;
            mem_rd_value_r <= ex_alu_res_r;
          end
        end
        StBusy: begin
          if (dbus_ack_i) begin
            r_state   <= StIdle;
            dbus_rd_o <= 1'b0;
            dbus_wr_o <= 1'b0;
            if (r_is_load) begin
              mem_rd_index_r <= r_idx;
              mem_rd_value_r <= w_load_val;
            end else begin
              mem_rd_index_r <= 5'd0;
            end
          end else begin
            mem_rd_index_r <= 5'd0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
